// File: rtl/if_prefetch_stage_pkg.sv
// Shared defaults for the instruction-fetch prefetch stage: word/PC geometry,
// reset PC and the derived {pc, instr} queue-entry width.
package if_prefetch_stage_pkg;

    localparam int          WORD_LEN_DEF     = 16;
    localparam int          INSTR_BYTES_DEF  = 2;
    localparam int          OFFSET_SHIFT_DEF = 1;
    localparam int          QDEPTH_DEF       = 4;
    localparam int unsigned RESET_PC_DEF     = 32'd0;
    localparam int          ENTRY_W_DEF      = 2 * WORD_LEN_DEF;

    function automatic int entry_width(input int word_len);
        return 2 * word_len;
    endfunction

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Bundle of the fetch stage's redirect inputs, instruction-memory bus and
// decode handoff; master is the fetch stage, slave is its environment.
interface if_prefetch_stage_if #(
    parameter int WORD_LEN = 16
);
    logic                br_taken;
    logic                is_jump;
    logic [WORD_LEN-1:0] redirect_pc;
    logic [WORD_LEN-1:0] br_offset;
    logic                imem_req;
    logic [WORD_LEN-1:0] imem_addr;
    logic                imem_rvalid;
    logic [WORD_LEN-1:0] imem_rdata;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_LEN-1:0] out_pc;
    logic [WORD_LEN-1:0] out_instr;

    modport master (
        input  br_taken, is_jump, redirect_pc, br_offset,
        input  imem_rvalid, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output br_taken, is_jump, redirect_pc, br_offset,
        output imem_rvalid, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/if_prefetch_stage_fetch_queue.sv
// if_fetch_queue: synchronous FIFO of {pc, instr} entries. Flush beats push;
// a pop in the flush cycle is still the head that decode consumed.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    // Pointer, count and storage next-state
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push_ok = push && (count_q != FULL);
        pop_ok  = pop && (count_q != '0);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_ok) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = (count_q != '0) ? mem_q[head_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: PC generation, credit-limited prefetch into a FIFO,
// redirect squashing. Define IF_PREFETCH_TRACE_EN for a simulation handoff trace.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter int          WORD_LEN     = WORD_LEN_DEF,
    parameter int          INSTR_BYTES  = INSTR_BYTES_DEF,
    parameter int          OFFSET_SHIFT = OFFSET_SHIFT_DEF,
    parameter int          QDEPTH       = QDEPTH_DEF,
    parameter int unsigned RESET_PC     = RESET_PC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    if_prefetch_stage_if.master  bus
);
    localparam int                  CW     = $clog2(QDEPTH) + 1;
    localparam int                  EW     = entry_width(WORD_LEN);
    localparam logic [WORD_LEN-1:0] RST_PC = WORD_LEN'(RESET_PC);
    localparam logic [WORD_LEN-1:0] STEP   = WORD_LEN'(INSTR_BYTES);
    localparam logic [CW:0]         LIMIT  = (CW+1)'(QDEPTH);

    logic [WORD_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_LEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]       q_count;
    logic [EW-1:0]       head_entry;
    logic [CW:0]         credit_used;
    logic [WORD_LEN-1:0] target;
    logic                redirect, issue, rsp_keep, rsp_drop, out_valid_s, q_pop, q_push;

    // Redirect target, credit check and next-state of PCs and counters
    always_comb begin
        redirect    = bus.br_taken | bus.is_jump;
        if (bus.is_jump) begin
            target = bus.br_offset << OFFSET_SHIFT;
        end else begin
            target = bus.redirect_pc + STEP + (bus.br_offset << OFFSET_SHIFT);
        end
        // Every slot is spoken for by a queued entry, a live request or a stale one
        credit_used = {1'b0, q_count} + {1'b0, outstanding_q} + {1'b0, drop_cnt_q};
        issue       = !rst && !redirect && (credit_used < LIMIT);
        rsp_drop    = bus.imem_rvalid && (drop_cnt_q != '0);
        rsp_keep    = bus.imem_rvalid && (drop_cnt_q == '0);
        out_valid_s = (q_count != '0);
        q_pop       = out_valid_s && bus.out_ready;
        q_push      = rsp_keep && !redirect;

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect) begin
            fetch_pc_d    = target;
            resp_pc_d     = target;
            outstanding_d = '0;
            drop_cnt_d    = drop_cnt_q + outstanding_q - CW'(bus.imem_rvalid);
        end else begin
            fetch_pc_d    = issue ? (fetch_pc_q + STEP) : fetch_pc_q;
            resp_pc_d     = rsp_keep ? (resp_pc_q + STEP) : resp_pc_q;
            outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_keep);
            drop_cnt_d    = drop_cnt_q - CW'(rsp_drop);
        end
    end

    // PC and in-flight bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RST_PC;
            resp_pc_q     <= RST_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    if_fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data ({resp_pc_q, bus.imem_rdata}),
        .pop       (q_pop),
        .flush     (redirect),
        .head_data (head_entry),
        .count     (q_count)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = out_valid_s;
    assign bus.out_pc    = head_entry[EW-1 -: WORD_LEN];
    assign bus.out_instr = head_entry[WORD_LEN-1:0];

`ifdef IF_PREFETCH_TRACE_EN
    // Simulation trace of accepted handoffs and redirects
    always_ff @(posedge clk) begin
        if (!rst && q_pop) begin
            $display("if_prefetch handoff pc=%b instr=%b", bus.out_pc, bus.out_instr);
        end
        if (!rst && redirect) begin
            $display("if_prefetch redirect target=%b", target);
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench for if_prefetch_stage: every fetched address is expected to
// come back in order unless a redirect or reset discards it first.
`timescale 1ns/1ps
module tb_if_prefetch_stage;

    typedef struct packed { logic [15:0] pc; logic [15:0] instr; } ent_t;
    typedef struct { int due; logic [15:0] addr; } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_prefetch_stage_if #(.WORD_LEN(16)) bus();

    if_prefetch_stage #(
        .WORD_LEN(16), .INSTR_BYTES(2), .OFFSET_SHIFT(1), .QDEPTH(4), .RESET_PC(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cycle    = 0;
    int    handoffs = 0;
    int    req_count = 0;
    int    lat_min  = 1;
    int    lat_max  = 1;
    int    last_due = 0;
    ent_t  exp_q[$];
    pend_t pend[$];
    logic [15:0] exp_fetch = 16'h0000;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'((a * 16'h9E37) ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] ref_target(input logic j, input logic [15:0] rpc,
                                               input logic [15:0] off);
        logic [15:0] sh;
        sh = 16'(off * 16'd2);
        if (j) return sh;
        return 16'(rpc + 16'd2 + sh);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Memory model: in-order responses, per-request latency in [lat_min, lat_max]
    always @(posedge clk) begin
        #2;
        if (pend.size() > 0 && pend[0].due == cycle) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 16'h0000;
        end
    end

    // Request capture: check fetch address stream and push expected handoffs
    always @(negedge clk) begin
        int d;
        if (rst) begin
            chk("req_in_rst", {31'd0, bus.imem_req}, 32'd0);
            exp_q.delete();
            pend.delete();
            exp_fetch = 16'h0000;
            last_due  = 0;
        end else if (bus.br_taken || bus.is_jump) begin
            chk("req_on_redirect", {31'd0, bus.imem_req}, 32'd0);
            exp_fetch = ref_target(bus.is_jump, bus.redirect_pc, bus.br_offset);
        end else if (bus.imem_req) begin
            chk("imem_addr", {16'd0, bus.imem_addr}, {16'd0, exp_fetch});
            exp_q.push_back('{pc: bus.imem_addr, instr: mem_word(bus.imem_addr)});
            d = cycle + $urandom_range(lat_max, lat_min);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{due: d, addr: bus.imem_addr});
            exp_fetch = 16'(exp_fetch + 16'd2);
            req_count++;
        end else begin
            exp_fetch = exp_fetch;
        end
    end

    // Output monitor: pop expected entries on handoff, discard on redirect
    always @(negedge clk) begin
        ent_t e;
        #1;
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got pc %h expected no entry", bus.out_pc);
                end else if (bus.out_ready) begin
                    e = exp_q.pop_front();
                    chk("out_pc", {16'd0, bus.out_pc}, {16'd0, e.pc});
                    chk("out_instr", {16'd0, bus.out_instr}, {16'd0, e.instr});
                    handoffs++;
                end else begin
                    chk("held_pc", {16'd0, bus.out_pc}, {16'd0, exp_q[0].pc});
                end
            end
            if (bus.br_taken || bus.is_jump) exp_q.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_once(input logic bt, input logic j, input logic [15:0] rpc,
                                 input logic [15:0] off);
        bus.br_taken = bt; bus.is_jump = j; bus.redirect_pc = rpc; bus.br_offset = off;
        tick();
        bus.br_taken = 1'b0; bus.is_jump = 1'b0;
    endtask

    initial begin
        int first_req, first_ov, h0;
        bus.br_taken = 1'b0; bus.is_jump = 1'b0;
        bus.redirect_pc = 16'h0000; bus.br_offset = 16'h0000;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 16'h0000;
        bus.out_ready = 1'b1;

        // Reset, latency 1, straight-line fetch with timing of first delivery
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_imem_addr", {16'd0, bus.imem_addr}, 32'd0);
        tick();
        rst = 1'b0;
        first_req = -1; first_ov = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #2;
            if (bus.imem_req && first_req < 0) first_req = cycle;
            if (bus.out_valid && first_ov < 0) first_ov = cycle;
        end
        chk("first_latency", 32'(first_ov - first_req), 32'd2);

        // Decode stalled: four requests then credit exhausted, head held
        tick(); rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0; bus.out_ready = 1'b0; req_count = 0;
        repeat (10) @(posedge clk);
        @(negedge clk); #2;
        chk("stall_req_count", 32'(req_count), 32'd4);
        chk("stall_head_pc", {16'd0, bus.out_pc}, 32'd0);
        tick();
        bus.out_ready = 1'b1; h0 = handoffs;
        repeat (4) @(negedge clk);
        #2;
        chk("release_burst", 32'(handoffs - h0), 32'd4);

        // Latency 3, branch with stale requests in flight
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #2;
            if (pend.size() == 2) break;
        end
        tick();
        redirect_once(1'b1, 1'b0, 16'h0010, 16'h0003);
        @(negedge clk); #2;
        chk("branch_target", {16'd0, bus.imem_addr}, 32'h0018);
        repeat (10) tick();

        // Branch and jump together: jump target wins
        redirect_once(1'b1, 1'b1, 16'h0100, 16'h0040);
        @(negedge clk); #2;
        chk("jump_wins", {16'd0, bus.imem_addr}, 32'h0080);
        repeat (8) tick();

        // Jump near top of address space: fetch and delivery wrap
        lat_min = 1; lat_max = 1;
        redirect_once(1'b0, 1'b1, 16'h1234, 16'h7FFE);
        @(negedge clk); #2;
        chk("wrap_start", {16'd0, bus.imem_addr}, 32'hFFFC);
        h0 = handoffs;
        repeat (12) tick();
        chk("wrap_delivered", 32'(handoffs - h0 >= 4), 32'd1);

        // Reset mid-stream with a stalled, loaded queue
        lat_min = 2; lat_max = 2; bus.out_ready = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        @(negedge clk); #2;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_imem_addr", {16'd0, bus.imem_addr}, 32'd0);
        tick();
        rst = 1'b0; bus.out_ready = 1'b1;
        repeat (10) tick();

        // Randomized traffic: stalls, redirects, variable latency
        lat_min = 1; lat_max = 5; h0 = handoffs;
        for (int i = 0; i < 3000; i++) begin
            bus.out_ready = ($urandom_range(9, 0) < 7);
            if ($urandom_range(19, 0) == 0) begin
                bus.br_taken    = $urandom_range(1, 0) == 1;
                bus.is_jump     = !bus.br_taken || ($urandom_range(3, 0) == 0);
                bus.redirect_pc = 16'($urandom);
                bus.br_offset   = 16'($urandom);
            end else begin
                bus.br_taken = 1'b0; bus.is_jump = 1'b0;
            end
            tick();
        end
        bus.br_taken = 1'b0; bus.is_jump = 1'b0;
        repeat (20) tick();
        chk("random_progress", 32'(handoffs - h0 > 500), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Parametrised next-generation instruction-fetch stage: PC generation plus a QDEPTH-entry prefetch queue in front of a variable-latency, in-order instruction memory. Redirects (taken branch/jump) come from downstream with their own base PC. Stale in-flight responses are squashed. Delivers {pc, instr} to decode over a valid/ready handshake instead of a freeze input.

Parameters:
WORD_LEN, 16, width of PC, instruction, offset
INSTR_BYTES, 2, PC increment per instruction
OFFSET_SHIFT, 1, left shift applied to br_offset for branch and jump targets
QDEPTH, 4, prefetch queue entries and max in-flight requests (power of 2, >=2)
RESET_PC, 0, PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
br_taken  in  1  branch redirect this cycle
is_jump  in  1  jump redirect this cycle
redirect_pc  in  WORD_LEN  PC of redirecting instruction
br_offset  in  WORD_LEN  branch/jump offset field
imem_req  out  1  fetch request, always accepted by memory
imem_addr  out  WORD_LEN  fetch address
imem_rvalid  in  1  response valid; responses in request order, latency >=1
imem_rdata  in  WORD_LEN  response instruction
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  WORD_LEN  head PC
out_instr  out  WORD_LEN  head instruction

Behaviour:
- State: fetch_pc, resp_pc, queue (count 0..QDEPTH, head/tail pointers), outstanding, drop_cnt.
- Reset, dominates all inputs, including mid-operation: fetch_pc=resp_pc=RESET_PC; count=outstanding=drop_cnt=0; out_valid=0; out_pc=out_instr=0. Responses arriving later are not tracked; the bench holds memory idle across reset.
- redirect = br_taken | is_jump.
- Targets, modulo 2^WORD_LEN:
  - Branch: redirect_pc + INSTR_BYTES + (br_offset << OFFSET_SHIFT).
  - Jump: br_offset << OFFSET_SHIFT, absolute.
  - If both are asserted, the jump wins.
- Issue:
  - imem_req = !rst & !redirect & (count + outstanding + drop_cnt < QDEPTH).
  - imem_addr = fetch_pc.
  - On issue: fetch_pc += INSTR_BYTES (wraps at 2^WORD_LEN); outstanding++.
- Response, on imem_rvalid:
  - If drop_cnt>0: discard; drop_cnt--.
  - Else: push {resp_pc, imem_rdata}; resp_pc += INSTR_BYTES; outstanding--.
  - The credit rule guarantees no push when full.
- Output:
  - out_valid = count>0; out_pc/out_instr = head entry, read combinationally from queue registers.
  - Pop when out_valid & out_ready. Push and pop in the same cycle are allowed; count is unchanged.
  - With out_ready=0 the head is stable.
- Redirect cycle:
  - Any pop in that cycle completes; then the queue is flushed (count=0).
  - drop_cnt_next = drop_cnt + outstanding - imem_rvalid; outstanding_next = 0.
  - A response arriving in the redirect cycle is discarded.
  - fetch_pc = resp_pc = target; no imem_req that cycle; first request at target next cycle.
- Latency: request issued cycle N with memory latency L → rvalid at N+L → out_valid at N+L+1. Redirect at cycle R → earliest out_valid at R+1+L+1.
- Queue wrap: head/tail pointers are log2(QDEPTH) bits and wrap naturally.

Optional Feature:
IF_PREFETCH_TRACE_EN
- Defined: simulation-only $display on every accepted handoff (out_valid & out_ready), printing out_pc and out_instr in binary; also one line per redirect showing the target.
- Undefined: no display code compiled.
- Ports and cycle behaviour are identical either way.

Decomposition:
- Shared defines file: WORD_LEN, INSTR_BYTES, OFFSET_SHIFT, RESET_PC defaults.
- Queue entry width = 2*WORD_LEN, defined as a derived constant there.
- One sub-module, if_fetch_queue: synchronous FIFO of {pc, instr} with push, pop, flush, count, head output; flush takes priority over push, and pop in the same cycle is honoured.
- Target adders and muxes stay inline.

Test Plan:
- Reset with imem latency 1, out_ready=1 → imem_addr 0x0000, 0x0002, 0x0004…; out_pc matches in order, first out_valid 2 cycles after first req; out_valid=0 during rst.
- out_ready=0, latency 1 → exactly 4 requests (0x0000–0x0006), then imem_req=0; out_pc holds 0x0000. Release → 0x0000–0x0006 delivered back-to-back, fetch resumes at 0x0008.
- Latency 3, br_taken with redirect_pc=0x0010, br_offset=0x0003, and 2 requests outstanding → next imem_addr 0x0018; the 2 stale responses are dropped; next out_pc 0x0018.
- br_taken and is_jump together, br_offset=0x0040, redirect_pc=0x0100 → target 0x0080 (jump wins).
- RESET_PC=0xFFFC, straight line → addresses 0xFFFC, 0xFFFE, 0x0000; out_pc wraps identically.
- rst asserted mid-stream with full queue and 2 outstanding, memory idled → next cycle out_valid=0, imem_addr=RESET_PC, counters zero.
